seven_segment_mux: RTL
======================

SEVEN_SEGMENT_MUX -- requirements
Module: seven_segment_mux

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of multiplexed digits (1..8).
REQ-002 SHALL have parameter REFRESH_DIV, default 100000, clock cycles per digit slot (>= 4).
REQ-003 SHALL have parameter GHOST, default 2, anode-off cycles at the start of each slot (< REFRESH_DIV).
REQ-004 SHALL have parameter LZ_BLANK, default 1; 1 enables leading-zero blanking.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-007 SHALL have port value, input, 4*DIGITS, hex nibbles; nibble i is digit i, and digit 0 is least significant.
REQ-008 SHALL have port dp, input, DIGITS, decimal-point request per digit.
REQ-009 SHALL have port load, input, 1, single-cycle strobe capturing value/dp.
REQ-010 SHALL have port blank, input, 1, level; forces all anodes off while high.
REQ-011 SHALL have port seg, output, 7, active-low segments; bit0=a ... bit6=g.
REQ-012 SHALL have port dp_n, output, 1, active-low decimal point.
REQ-013 SHALL have port an, output, DIGITS, active-low anode enables; bit i drives digit i.
REQ-014 SHALL have port frame, output, 1, one-cycle pulse on the last cycle of digit DIGITS-1's slot.

Function
REQ-015 SHALL keep a slot counter 0..REFRESH_DIV-1 that increments every cycle and wraps to 0.
REQ-016 SHALL keep a digit index 0..DIGITS-1 that advances on slot-counter wrap and wraps from DIGITS-1 to 0.
REQ-017 SHALL assert frame when the slot counter = REFRESH_DIV-1 and the index = DIGITS-1.
REQ-018 SHALL, on load, capture value/dp into a pending register and set a pending flag.
REQ-019 SHALL copy pending into the display register and clear the flag on the frame cycle, so no frame mixes old and new data.
REQ-020 SHALL, when load and frame coincide, write the new value/dp directly into the display register and leave the pending flag clear.
REQ-021 SHALL keep only the newest of multiple loads within one frame.
REQ-022 SHALL decode the indexed display nibble as active-low hex glyphs: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110 (listed g..a).
REQ-023 SHALL, with LZ_BLANK=1, blank digit i>0 (seg=1111111) when nibble i and all higher nibbles are 0; digit 0 is never blanked.
REQ-024 SHALL drive dp_n = ~dp[i] of the display register for the active digit, including leading-zero-blanked digits.
REQ-025 SHALL drive an all-ones, seg=1111111 and dp_n=1 while the slot counter < GHOST.
REQ-026 SHALL, for the remaining slot cycles, drive an with only bit[index] low.
REQ-027 SHALL register seg, dp_n, an and frame, giving one cycle of latency from counter/index state to pins.
REQ-028 SHALL, while blank=1, force an all-ones, seg=1111111 and dp_n=1, while counters and load/pending logic keep running.

Reset
REQ-029 SHALL, while rst=1, clear the slot counter, index, pending flag, pending register and display register to 0.
REQ-030 SHALL, while rst=1, drive an all-ones, seg=1111111, dp_n=1 and frame=0.
REQ-031 SHALL give reset priority over load, and a mid-frame reset SHALL discard pending data.
REQ-032 SHALL, after rst falls, begin at slot 0 of digit 0, with the first anode enable GHOST+1 cycles later.

Verification (DIGITS=4, REFRESH_DIV=8, GHOST=2, LZ_BLANK=1)
REQ-033 SHALL verify scan: after reset → an=1111 for cycles 1-2, an=1110 for cycles 3-8, then 1101 in the next slot, with frame pulsing every 32 cycles.
REQ-034 SHALL verify load tear-freedom: load 16'h1234 mid-frame → digits show old data (0) until frame, then digit0 seg=0011001 ('4') and digit3 seg=1111001 ('1').
REQ-035 SHALL verify leading-zero blanking: value=16'h0050 → digits 3 and 2 show seg=1111111, digit1 shows '5', and digit0 shows '0'.
REQ-036 SHALL verify load on the frame cycle: load 16'hABCD coincident with frame → the next frame shows ABCD, and the pending flag stays 0.
REQ-037 SHALL verify blank and dp: blank=1 → an=1111 in every cycle, and the counters keep running; dp=4'b0100 with value=16'h0007 → digit2 seg blanked and dp_n=0.
REQ-038 SHALL verify reset mid-frame: load 16'hFFFF, then rst before frame → after release all digits show '0' (digits 1-3 blanked), and FFFF never appears.

Source files
------------

// File: rtl/seven_segment_mux.sv
// seven_segment_mux
//   Time-multiplexed driver for a common-anode hex display of DIGITS digits.
//   Each digit gets a slot of REFRESH_DIV clock cycles. The first GHOST cycles
//   of every slot keep all anodes dark so the previous digit's segments cannot
//   bleed into the next one. New data is staged in a pending register and
//   promoted to the display register only at the end of a frame, so one scan
//   never mixes old and new digits.
//
// Ports
//   clk    in   single clock, rising edge
//   rst    in   synchronous active-high reset
//   value  in   [4*DIGITS] hex nibbles, nibble i -> digit i (digit 0 = LSD)
//   dp     in   [DIGITS] decimal-point request per digit
//   load   in   one-cycle strobe capturing value/dp
//   blank  in   level, forces all anodes/segments off while high
//   seg    out  [7] active-low segments, bit0=a .. bit6=g
//   dp_n   out  active-low decimal point
//   an     out  [DIGITS] active-low anode enables, bit i -> digit i
//   frame  out  one-cycle pulse on the last cycle of digit DIGITS-1's slot

module seven_segment_mux #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int GHOST       = 2,
  parameter int LZ_BLANK    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  load,
  input  logic                  blank,
  output logic [6:0]            seg,
  output logic                  dp_n,
  output logic [DIGITS-1:0]     an,
  output logic                  frame
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0] GHOST_END = CNT_W'(GHOST);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                pend_flag_q, pend_flag_d;
  logic [4*DIGITS-1:0] pend_val_q, pend_val_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic [4*DIGITS-1:0] disp_val_q, disp_val_d;
  logic [DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_n_q, dp_n_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                frame_q, frame_d;

  logic                frame_cond;
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_lz;
  logic [DIGITS-1:0]   hi_zero;
  logic                zero_run;

  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  // Scan counters
  always_comb begin
    frame_cond = (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);
    cnt_d      = cnt_q + 1'b1;
    idx_d      = idx_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // Pending/display registers. Promotion happens only on the frame cycle; a
  // load on that same cycle bypasses pending so it is not delayed a frame.
  always_comb begin
    pend_flag_d = pend_flag_q;
    pend_val_d  = pend_val_q;
    pend_dp_d   = pend_dp_q;
    disp_val_d  = disp_val_q;
    disp_dp_d   = disp_dp_q;
    if (load && frame_cond) begin
      disp_val_d  = value;
      disp_dp_d   = dp;
      pend_flag_d = 1'b0;
    end else if (frame_cond) begin
      // Pending contents may be stale after a bypass load, so only the flag
      // authorises a copy.
      if (pend_flag_q) begin
        disp_val_d = pend_val_q;
        disp_dp_d  = pend_dp_q;
      end
      pend_flag_d = 1'b0;
    end else if (load) begin
      pend_val_d  = value;
      pend_dp_d   = dp;
      pend_flag_d = 1'b1;
    end
  end

  // Digit select and leading-zero detection. hi_zero[i] is set when nibble i
  // and every nibble above it are zero.
  always_comb begin
    zero_run = 1'b1;
    hi_zero  = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run   = zero_run & (disp_val_q[4*i +: 4] == 4'h0);
      hi_zero[i] = zero_run;
    end
    cur_nib = 4'h0;
    cur_dp  = 1'b0;
    cur_lz  = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nib = disp_val_q[4*i +: 4];
        cur_dp  = disp_dp_q[i];
        cur_lz  = (LZ_BLANK != 0) && (i != 0) && hi_zero[i];
      end
    end
  end

  // Pin drive, registered one cycle behind the counter state
  always_comb begin
    seg_d   = 7'h7F;
    dp_n_d  = 1'b1;
    an_d    = '1;
    frame_d = frame_cond;
    if (!blank && (cnt_q >= GHOST_END)) begin
      an_d   = ~(DIGITS'(1) << idx_q);
      seg_d  = cur_lz ? 7'h7F : hex_glyph(cur_nib);
      dp_n_d = ~cur_dp;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      pend_flag_q <= 1'b0;
      pend_val_q  <= '0;
      pend_dp_q   <= '0;
      disp_val_q  <= '0;
      disp_dp_q   <= '0;
      seg_q       <= 7'h7F;
      dp_n_q      <= 1'b1;
      an_q        <= '1;
      frame_q     <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      pend_flag_q <= pend_flag_d;
      pend_val_q  <= pend_val_d;
      pend_dp_q   <= pend_dp_d;
      disp_val_q  <= disp_val_d;
      disp_dp_q   <= disp_dp_d;
      seg_q       <= seg_d;
      dp_n_q      <= dp_n_d;
      an_q        <= an_d;
      frame_q     <= frame_d;
    end
  end

  assign seg   = seg_q;
  assign dp_n  = dp_n_q;
  assign an    = an_q;
  assign frame = frame_q;

endmodule
